// File: rtl/seq_det_pkg.sv
// Shared constants and elaboration-time helpers for the parametrised sequence detector.
// The transition table is derived here from the pattern with the KMP failure rule.
package seq_det_pkg;

  localparam int S0 = 0;

  function automatic int clog2(input int value);
    return $clog2(value);
  endfunction

  // MATCH is the last state, so its encoding equals the pattern length
  function automatic int match_state(input int len);
    return len;
  endfunction

  // Bit idx of the pattern in arrival order (idx 0 is the first bit received)
  function automatic logic pattern_bit_f(input logic [15:0] pat, input int len, input int idx);
    logic [15:0] shifted;
    shifted = pat >> (len - 1 - idx);
    return shifted[0];
  endfunction

  function automatic int border_len_f(input logic [15:0] pat, input int len);
    int  result;
    logic ok;
    result = 0;
    for (int m = 1; m < len; m++) begin
      ok = 1'b1;
      for (int i = 0; i < m; i++) begin
        if (pattern_bit_f(pat, len, i) != pattern_bit_f(pat, len, len - m + i)) ok = 1'b0;
      end
      if (ok) result = m;
    end
    return result;
  endfunction

  function automatic int next_state_f(input int state, input logic b, input logic [15:0] pat,
                                      input int len, input int overlap);
    int   k;
    int   idx;
    int   result;
    logic found;
    logic ok;
    logic s_bit;
    if (state >= len) k = (overlap != 0) ? border_len_f(pat, len) : S0;
    else              k = state;
    result = S0;
    found  = 1'b0;
    if (pattern_bit_f(pat, len, k) == b) begin
      result = k + 1;
      found  = 1'b1;
    end
    // Longest pattern prefix that is a suffix of (first k pattern bits, b)
    for (int j = k; j >= 1; j--) begin
      if (!found) begin
        ok = 1'b1;
        for (int i = 0; i < j; i++) begin
          idx   = k + 1 - j + i;
          s_bit = (idx == k) ? b : pattern_bit_f(pat, len, idx);
          if (pattern_bit_f(pat, len, i) != s_bit) ok = 1'b0;
        end
        if (ok) begin
          result = j;
          found  = 1'b1;
        end
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/seq_match_counter.sv
// Saturating match counter; a clear coinciding with an increment leaves a count of one.
module seq_match_counter #(
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inc,
  input  logic                 clear,
  output logic [CNT_WIDTH-1:0] count
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  always_ff @(posedge clk) begin
    if (rst)                          count <= '0;
    else if (clear && inc)            count <= CNT_WIDTH'(1);
    else if (clear)                   count <= '0;
    else if (inc && count != CNT_MAX) count <= count + CNT_WIDTH'(1);
  end

endmodule

// File: rtl/seq_detector_param.sv
// Moore serial pattern detector; the next-state table is fully resolved at elaboration,
// so the runtime logic is just a constant lookup on (state, in).
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int                     PATTERN_LEN = 4,
  parameter logic [PATTERN_LEN-1:0] PATTERN     = 4'b1101,
  parameter int                     OVERLAP     = 0,
  parameter int                     CNT_WIDTH   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in,
  input  logic                 in_valid,
  input  logic                 count_clear,
  output logic                 out,
  output logic [CNT_WIDTH-1:0] match_count
);

  localparam int               SW    = clog2(PATTERN_LEN + 1);
  localparam logic [SW-1:0]    ST_S0 = SW'(S0);
  localparam logic [SW-1:0]    MATCH = SW'(match_state(PATTERN_LEN));

  logic [SW-1:0] state;
  logic [SW-1:0] state_next;
  logic [SW-1:0] ns_on0 [0:PATTERN_LEN];
  logic [SW-1:0] ns_on1 [0:PATTERN_LEN];
  logic          match_inc;

  for (genvar s = 0; s <= PATTERN_LEN; s++) begin : g_table
    localparam logic [SW-1:0] NS0 = SW'(next_state_f(s, 1'b0, 16'(PATTERN), PATTERN_LEN, OVERLAP));
    localparam logic [SW-1:0] NS1 = SW'(next_state_f(s, 1'b1, 16'(PATTERN), PATTERN_LEN, OVERLAP));
    assign ns_on0[s] = NS0;
    assign ns_on1[s] = NS1;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_S0;
    else     state <= state_next;
  end

  // Gaps in in_valid freeze the FSM, so out may stay high across them
  always_comb begin
    state_next = state;
    if (in_valid) begin
      for (int s = 0; s <= PATTERN_LEN; s++) begin
        if (state == SW'(s)) state_next = in ? ns_on1[s] : ns_on0[s];
      end
    end
  end

  always_comb begin
    out       = (state == MATCH);
    match_inc = in_valid && (state_next == MATCH);
  end

  seq_match_counter #(
    .CNT_WIDTH(CNT_WIDTH)
  ) u_counter (
    .clk  (clk),
    .rst  (rst),
    .inc  (match_inc),
    .clear(count_clear),
    .count(match_count)
  );

endmodule

// File: tb/tb_seq_detector_param.sv
// Drives five detector configurations with one shared stream and compares each
// against a history-window reference model of the matching rules.
module tb_seq_detector_param;

  logic clk = 1'b0;
  logic rst, din, in_valid, count_clear;
  logic       out_a, out_b, out_c, out_d, out_e;
  logic [7:0] cnt_a, cnt_b, cnt_c, cnt_d;
  logic [1:0] cnt_e;

  int nCompared   = 0;
  int nMismatched = 0;
  int tbCycle     = 0;

  // Reference configuration per instance: A,B = 1101 non-ovl/ovl, C,D = 11 ovl/non-ovl, E = 1101 with 2-bit counter
  int patVal [5] = '{4'b1101, 4'b1101, 2'b11, 2'b11, 4'b1101};
  int patLen [5] = '{4, 4, 2, 2, 4};
  int ovMode [5] = '{0, 1, 1, 0, 0};
  int cntMax [5] = '{255, 255, 255, 255, 3};
  string names [5] = '{"A", "B", "C", "D", "E"};

  bit hist[$];
  int sinceMatch [5];
  int expOut [5];
  int expCnt [5];

  always #5 clk = ~clk;

  seq_detector_param #(.PATTERN_LEN(4), .PATTERN(4'b1101), .OVERLAP(0), .CNT_WIDTH(8)) dut_a (
    .clk(clk), .rst(rst), .in(din), .in_valid(in_valid), .count_clear(count_clear),
    .out(out_a), .match_count(cnt_a));
  seq_detector_param #(.PATTERN_LEN(4), .PATTERN(4'b1101), .OVERLAP(1), .CNT_WIDTH(8)) dut_b (
    .clk(clk), .rst(rst), .in(din), .in_valid(in_valid), .count_clear(count_clear),
    .out(out_b), .match_count(cnt_b));
  seq_detector_param #(.PATTERN_LEN(2), .PATTERN(2'b11), .OVERLAP(1), .CNT_WIDTH(8)) dut_c (
    .clk(clk), .rst(rst), .in(din), .in_valid(in_valid), .count_clear(count_clear),
    .out(out_c), .match_count(cnt_c));
  seq_detector_param #(.PATTERN_LEN(2), .PATTERN(2'b11), .OVERLAP(0), .CNT_WIDTH(8)) dut_d (
    .clk(clk), .rst(rst), .in(din), .in_valid(in_valid), .count_clear(count_clear),
    .out(out_d), .match_count(cnt_d));
  seq_detector_param #(.PATTERN_LEN(4), .PATTERN(4'b1101), .OVERLAP(0), .CNT_WIDTH(2)) dut_e (
    .clk(clk), .rst(rst), .in(din), .in_valid(in_valid), .count_clear(count_clear),
    .out(out_e), .match_count(cnt_e));

  task automatic checkOutput(input string tag, input int observed, input int expected);
    nCompared++;
    if (observed != expected) begin
      nMismatched++;
      $display("[TB] FAIL %s cycle %0d: got %0d expected %0d", tag, tbCycle, observed, expected);
    end
  endtask

  function automatic bit windowMatch(input int i);
    int n;
    n = hist.size();
    if (n < patLen[i]) return 1'b0;
    for (int j = 0; j < patLen[i]; j++) begin
      if (hist[n - patLen[i] + j] != 1'((patVal[i] >> (patLen[i] - 1 - j)) & 1)) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Match = last LEN accepted bits equal the pattern; non-overlap also needs LEN fresh bits since the previous match
  task automatic modelStep(input logic r, input logic v, input logic d, input logic c);
    bit inc;
    if (r) begin
      hist.delete();
      for (int i = 0; i < 5; i++) begin
        sinceMatch[i] = 0;
        expOut[i]     = 0;
        expCnt[i]     = 0;
      end
    end else begin
      if (v) begin
        hist.push_back(d);
        if (hist.size() > 16) void'(hist.pop_front());
      end
      for (int i = 0; i < 5; i++) begin
        inc = 1'b0;
        if (v) begin
          sinceMatch[i]++;
          if (windowMatch(i) && (ovMode[i] != 0 || sinceMatch[i] >= patLen[i])) begin
            inc           = 1'b1;
            sinceMatch[i] = 0;
          end
          expOut[i] = int'(inc);
        end
        if (c)                              expCnt[i] = inc ? 1 : 0;
        else if (inc && expCnt[i] < cntMax[i]) expCnt[i]++;
      end
    end
  endtask

  task automatic applyStimulus(input logic r, input logic v, input logic d, input logic c);
    @(negedge clk);
    rst         = r;
    in_valid    = v;
    din         = d;
    count_clear = c;
    @(posedge clk);
    tbCycle++;
    modelStep(r, v, d, c);
    #1;
    checkOutput({names[0], ".out"}, int'(out_a), expOut[0]);
    checkOutput({names[0], ".cnt"}, int'(cnt_a), expCnt[0]);
    checkOutput({names[1], ".out"}, int'(out_b), expOut[1]);
    checkOutput({names[1], ".cnt"}, int'(cnt_b), expCnt[1]);
    checkOutput({names[2], ".out"}, int'(out_c), expOut[2]);
    checkOutput({names[2], ".cnt"}, int'(cnt_c), expCnt[2]);
    checkOutput({names[3], ".out"}, int'(out_d), expOut[3]);
    checkOutput({names[3], ".cnt"}, int'(cnt_d), expCnt[3]);
    checkOutput({names[4], ".out"}, int'(out_e), expOut[4]);
    checkOutput({names[4], ".cnt"}, int'(cnt_e), expCnt[4]);
  endtask

  task automatic sendBits(input logic [15:0] bits, input int len);
    for (int i = len - 1; i >= 0; i--) applyStimulus(1'b0, 1'b1, bits[i], 1'b0);
  endtask

  initial begin
    logic [3:0] gapBits;
    rst = 1'b1; din = 1'b0; in_valid = 1'b0; count_clear = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);

    sendBits(16'b1101101, 7);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);

    sendBits(16'b1111, 4);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);

    gapBits = 4'b1101;
    for (int i = 3; i >= 0; i--) begin
      applyStimulus(1'b0, 1'b1, gapBits[i], 1'b0);
      for (int g = 0; g < 3; g++) applyStimulus(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);

    for (int m = 0; m < 5; m++) sendBits(16'b1101, 4);
    sendBits(16'b110, 3);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);

    sendBits(16'b110, 3);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    sendBits(16'b1101, 4);

    for (int n = 0; n < 400; n++) begin
      applyStimulus(1'($urandom_range(0, 99) == 0), 1'($urandom_range(0, 3) != 0),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 49) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/seq_detector_param.md
# seq_detector_param

Parametrised Moore-style serial bit-pattern detector, the general successor to the team's fixed-pattern detectors. The matched pattern, its length and the overlap mode are all compile-time parameters. It adds an input-valid qualifier and a saturating match counter with synchronous clear. It sits directly on a serial bit stream and feeds status or interrupt logic.

## Interface
- `PATTERN_LEN`, default 4: pattern length in bits; legal range 2..16.
- `PATTERN`, default 4'b1101: pattern bits. Bit `PATTERN_LEN-1` is the first bit received.
- `OVERLAP`, default 0: detection mode.
  - 0 = non-overlapping; after a match, detection restarts from scratch.
  - 1 = overlapping; the longest proper prefix/suffix border of the pattern is retained.
- `CNT_WIDTH`, default 8: width of the match counter.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in`  in  1  serial data bit.
- `in_valid`  in  1  qualifier; `in` is consumed only on edges where `in_valid`=1.
- `count_clear`  in  1  synchronous clear of `match_count`.
- `out`  out  1  Moore detect flag; high while the FSM is in the MATCH state.
- `match_count`  out  CNT_WIDTH  number of matches since reset or clear; saturating.

## Operation
- The FSM has `PATTERN_LEN+1` states, S0..S`PATTERN_LEN`.
  - Sk means the last k accepted bits equal the first k pattern bits.
  - S`PATTERN_LEN` is MATCH.
- Transition from Sk (k < `PATTERN_LEN`) on accepted bit b:
  - If b equals pattern bit k, go to Sk+1.
  - Otherwise, go to Sj, where j is the longest pattern prefix that is a suffix of (first k pattern bits followed by b). This is the KMP failure rule.
- Transition from MATCH on accepted bit b:
  - OVERLAP=0: transition as from S0.
  - OVERLAP=1: transition as from Sm, where m is the longest proper border of `PATTERN`.
- All transitions are resolved at elaboration. The runtime next-state logic is a pure function of (state, b).
- `in_valid`=0: state holds, and `out` holds its current value (it may stay high across gaps).
- `out` = 1 if and only if state = MATCH. It depends only on state (Moore).
- `match_count` increments by 1 on each edge where the next state is MATCH and `in_valid`=1.
  - It saturates at 2^CNT_WIDTH−1 and never wraps.
- If `count_clear` and an increment occur on the same edge, `match_count` becomes 1.
- If `count_clear` is asserted alone, `match_count` becomes 0. It has no effect on the FSM.

## Timing
- Reset values: state = S0, `out`=0, `match_count`=0.
- `rst` takes priority over `in_valid` and `count_clear`.
- Asserting `rst` mid-pattern discards any partial match.
- Latency: when the last pattern bit is accepted at edge N, `out` rises after edge N (zero extra cycles of latency).
- `out` falls after the next accepted bit, unless that bit completes another match (overlap only). It can be continuously high for consecutive matches.
- `match_count` updates on the same edge that the state enters MATCH.
- No combinational path exists from `in` to `out`.

## Structure
- Package `seq_det_pkg` contains:
  - `clog2` for the state width, `$clog2(PATTERN_LEN+1)`;
  - the elaboration-time functions `next_state_f(state, bit, PATTERN, PATTERN_LEN, OVERLAP)` and `border_len_f(PATTERN, PATTERN_LEN)`;
  - state-encoding constants S0 and MATCH.
- Sub-module `seq_match_counter` (parameter CNT_WIDTH; ports `clk`, `rst`, `inc`, `clear`, `count`) implements the saturating counter with clear/increment priority.
- The top level contains the state register, the next-state function and the Moore output decode.

## Test plan
- PATTERN=1101, OVERLAP=0, stream 1,1,0,1,1,0,1 (`in_valid`=1 throughout) -> `out` high after bit 4 only; `match_count`=1.
- Same stream with OVERLAP=1 -> `out` high after bits 4 and 7; `match_count`=2.
- PATTERN_LEN=2, PATTERN=11, stream 1,1,1,1:
  - OVERLAP=1 -> matches after bits 2, 3 and 4; `out` stays high from bit 2 to bit 4; count=3.
  - OVERLAP=0 -> matches after bits 2 and 4; count=2.
- PATTERN=1101, stream 1,1,0,1 with `in_valid`=0 for 3 cycles between each bit, and garbage on `in` during the gaps -> exactly one match; `out` stays high until the next valid bit.
- CNT_WIDTH=2, PATTERN=1101: 5 matches -> count saturates at 3. Then `count_clear` on the same edge as a 6th match -> count=1.
- Stream 1,1,0 then `rst` for 1 cycle, then 1 -> no match; state S1; `out`=0 and `match_count`=0 immediately after the reset edge.
